// File: rtl/alu_rs_pkg.sv
// alu_rs shared definitions: ROB tag width and ALU opcodes.
// Opcode 0 means idle; the issue register drives it when empty.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

package alu_rs_pkg;

  localparam int ROB_TAG_W = `ROB_ENTRY_WIDTH;

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] ADD  = 4'd1;
  localparam logic [3:0] SUB  = 4'd2;
  localparam logic [3:0] AND  = 4'd3;
  localparam logic [3:0] OR   = 4'd4;
  localparam logic [3:0] XOR  = 4'd5;
  localparam logic [3:0] SLL  = 4'd6;
  localparam logic [3:0] SRL  = 4'd7;
  localparam logic [3:0] SRA  = 4'd8;
  localparam logic [3:0] SLT  = 4'd9;
  localparam logic [3:0] SLTU = 4'd10;
  localparam logic [3:0] OUTA = 4'd11;
  localparam logic [3:0] OUTB = 4'd12;

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs bus: dispatch, CDB snoop, issue and occupancy.
// master = dispatch/CDB side, slave = the station.
interface alu_rs_if #(
  parameter int TAG_W = `ROB_ENTRY_WIDTH,
  parameter int OCC_W = 3
);
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_op;
  logic [31:0]      disp_vj;
  logic [31:0]      disp_vk;
  logic [TAG_W-1:0] disp_qj;
  logic [TAG_W-1:0] disp_qk;
  logic             disp_qj_pend;
  logic             disp_qk_pend;
  logic [TAG_W-1:0] disp_dest;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             iss_valid;
  logic [3:0]       ALUOp;
  logic [31:0]      ALUSrcA;
  logic [31:0]      ALUSrcB;
  logic [TAG_W-1:0] Dest;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output disp_valid, disp_op, disp_vj, disp_vk,
    output disp_qj, disp_qk, disp_qj_pend,
    output disp_qk_pend, disp_dest,
    output cdb_valid, cdb_tag, cdb_data,
    input  disp_ready, iss_valid, ALUOp,
    input  ALUSrcA, ALUSrcB, Dest, occupancy
  );

  modport slave (
    input  disp_valid, disp_op, disp_vj, disp_vk,
    input  disp_qj, disp_qk, disp_qj_pend,
    input  disp_qk_pend, disp_dest,
    input  cdb_valid, cdb_tag, cdb_data,
    output disp_ready, iss_valid, ALUOp,
    output ALUSrcA, ALUSrcB, Dest, occupancy
  );
endinterface

// File: rtl/alu_rs_pick.sv
// alu_rs_pick: lowest-index priority encoder.
// Returns a one-hot grant and an any-request flag.
module alu_rs_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         valid
);
  // req & -req isolates the lowest set bit
  assign gnt   = req & (~req + N'(1));
  assign valid = |req;
endmodule

// File: rtl/alu_rs.sv
// alu_rs: integer ALU reservation station with CDB snoop.
// Define ALU_RS_WAKEUP_BYPASS_EN for same-cycle wakeup-to-select.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = `ROB_ENTRY_WIDTH
) (
  input logic   clk,
  input logic   rst_n,
  input logic   flush,
  alu_rs_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int OW = IW + 1;

  logic [ENTRIES-1:0] busy, pj, pk;
  logic [3:0]         op   [ENTRIES];
  logic [31:0]        vj   [ENTRIES];
  logic [31:0]        vk   [ENTRIES];
  logic [TAG_W-1:0]   qj   [ENTRIES];
  logic [TAG_W-1:0]   qk   [ENTRIES];
  logic [TAG_W-1:0]   dest [ENTRIES];

  logic [ENTRIES-1:0] wj, wk, rdy, free;
  logic [ENTRIES-1:0] fgnt, rgnt;
  logic               fval, rval, fire;
  logic               cj, ck;
  logic [IW-1:0]      sel;
  logic [31:0]        a, b;
  logic [OW-1:0]      occ;

  logic               iss_v;
  logic [3:0]         iss_op;
  logic [31:0]        iss_a, iss_b;
  logic [TAG_W-1:0]   iss_d;

  always_comb begin
    wj  = '0;
    wk  = '0;
    rdy = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wj[i] = busy[i] & pj[i] & bus.cdb_valid
            & (qj[i] == bus.cdb_tag);
      wk[i] = busy[i] & pk[i] & bus.cdb_valid
            & (qk[i] == bus.cdb_tag);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      rdy[i] = busy[i] & (~pj[i] | wj[i])
             & (~pk[i] | wk[i]);
`else
      rdy[i] = busy[i] & ~pj[i] & ~pk[i];
`endif
    end
  end

  assign free = ~busy;

  alu_rs_pick #(.N(ENTRIES)) u_free (
    .req   (free),
    .gnt   (fgnt),
    .valid (fval)
  );

  alu_rs_pick #(.N(ENTRIES)) u_rdy (
    .req   (rdy),
    .gnt   (rgnt),
    .valid (rval)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (rgnt[i]) sel = IW'(i);
  end

  always_comb begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    a = wj[sel] ? bus.cdb_data : vj[sel];
    b = wk[sel] ? bus.cdb_data : vk[sel];
`else
    a = vj[sel];
    b = vk[sel];
`endif
  end

  assign fire = bus.disp_valid & fval;
  assign cj = bus.disp_qj_pend & bus.cdb_valid
            & (bus.disp_qj == bus.cdb_tag);
  assign ck = bus.disp_qk_pend & bus.cdb_valid
            & (bus.disp_qk == bus.cdb_tag);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy   <= '0;
      pj     <= '0;
      pk     <= '0;
      occ    <= '0;
      iss_v  <= 1'b0;
      iss_op <= IDLE;
      iss_a  <= '0;
      iss_b  <= '0;
      iss_d  <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wj[i]) begin
          vj[i] <= bus.cdb_data;
          pj[i] <= 1'b0;
        end
        if (wk[i]) begin
          vk[i] <= bus.cdb_data;
          pk[i] <= 1'b0;
        end
        if (rgnt[i]) busy[i] <= 1'b0;
        if (fire && fgnt[i]) begin
          busy[i] <= 1'b1;
          op[i]   <= bus.disp_op;
          vj[i]   <= cj ? bus.cdb_data : bus.disp_vj;
          vk[i]   <= ck ? bus.cdb_data : bus.disp_vk;
          qj[i]   <= bus.disp_qj;
          qk[i]   <= bus.disp_qk;
          pj[i]   <= bus.disp_qj_pend & ~cj;
          pk[i]   <= bus.disp_qk_pend & ~ck;
          dest[i] <= bus.disp_dest;
        end
      end
      occ    <= occ + OW'(fire) - OW'(rval);
      iss_v  <= rval;
      iss_op <= rval ? op[sel] : IDLE;
      iss_a  <= rval ? a : '0;
      iss_b  <= rval ? b : '0;
      iss_d  <= rval ? dest[sel] : '0;
    end
  end

  assign bus.disp_ready = fval;
  assign bus.occupancy  = occ;
  assign bus.iss_valid  = iss_v;
  assign bus.ALUOp      = iss_op;
  assign bus.ALUSrcA    = iss_a;
  assign bus.ALUSrcB    = iss_b;
  assign bus.Dest       = iss_d;
endmodule
